// File: rtl/pipelined_memory_interface.sv
// Load/store front end for the shared memory bus: registered command stage,
// in-order tracking of outstanding reads, and misalignment detection.
module pipelined_memory_interface #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_format,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [31:0]           req_write_data,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_read_data,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic                  bus_read_enable,
  output logic                  bus_write_enable,
  output logic [3:0]            bus_byte_enable,
  output logic [31:0]           bus_write_data,
  input  logic                  bus_wait_req,
  input  logic                  bus_valid,
  input  logic [31:0]           bus_read_data
);

  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [2:0] fmt;
    logic [1:0] off;
  } track_t;

  logic [ADDR_WIDTH-1:0] bus_address_q, bus_address_d;
  logic                  bus_read_enable_q, bus_read_enable_d;
  logic                  bus_write_enable_q, bus_write_enable_d;
  logic [3:0]            bus_byte_enable_q, bus_byte_enable_d;
  logic [31:0]           bus_write_data_q, bus_write_data_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_read_data_q, rsp_read_data_d;
  logic                  rsp_error_q, rsp_error_d;
  logic                  resp_pending_q, resp_pending_d;
  track_t                fifo_q [MAX_OUTSTANDING];
  track_t                fifo_d [MAX_OUTSTANDING];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic [1:0]  off;
  logic        misaligned, load_aligned, cmd_active, fifo_empty, fifo_has_room;
  logic        accept, push, pop;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, shifted, load_data;
  track_t      head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign off           = req_address[1:0];
  assign misaligned    = (req_format[1:0] == 2'b01 && off[0]) || (req_format[1] && off != 2'b00);
  assign load_aligned  = !req_write && !misaligned;
  assign cmd_active    = bus_read_enable_q || bus_write_enable_q;
  assign fifo_empty    = (cnt_q == '0);
  assign fifo_has_room = (cnt_q < CntW'(MAX_OUTSTANDING));

  // Stores and errors wait for an idle pipe so their responses stay in order.
  assign req_ready = (!cmd_active || !bus_wait_req) && fifo_has_room &&
                     (load_aligned || (fifo_empty && !cmd_active && !resp_pending_q));

  assign accept = req_valid && req_ready;
  assign push   = accept && load_aligned;
  assign pop    = bus_valid && !fifo_empty;
  assign head   = fifo_q[rd_ptr_q];

  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = req_write_data << {off, 3'b000};
    case (req_format[1:0])
      2'b00:   lane_be = 4'b0001 << off;
      2'b01:   lane_be = 4'b0011 << off;
      default: lane_be = 4'b1111;
    endcase
  end

  always_comb begin
    shifted   = bus_read_data >> {head.off, 3'b000};
    load_data = shifted;
    case (head.fmt[1:0])
      2'b00:   load_data = {{24{!head.fmt[2] && shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{!head.fmt[2] && shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    bus_address_d      = bus_address_q;
    bus_read_enable_d  = bus_read_enable_q;
    bus_write_enable_d = bus_write_enable_q;
    bus_byte_enable_d  = bus_byte_enable_q;
    bus_write_data_d   = bus_write_data_q;
    if (cmd_active && !bus_wait_req) begin
      bus_address_d      = '0;
      bus_read_enable_d  = 1'b0;
      bus_write_enable_d = 1'b0;
      bus_byte_enable_d  = '0;
      bus_write_data_d   = '0;
    end
    if (accept && !misaligned) begin
      bus_address_d      = {req_address[ADDR_WIDTH-1:2], 2'b00};
      bus_read_enable_d  = !req_write;
      bus_write_enable_d = req_write;
      bus_byte_enable_d  = lane_be;
      bus_write_data_d   = lane_wdata;
    end

    rsp_valid_d     = 1'b0;
    rsp_read_data_d = '0;
    rsp_error_d     = 1'b0;
    resp_pending_d  = 1'b0;
    if (accept && misaligned) begin
      rsp_valid_d    = 1'b1;
      rsp_error_d    = 1'b1;
      resp_pending_d = 1'b1;
    end
    if (bus_write_enable_q && !bus_wait_req) begin
      rsp_valid_d    = 1'b1;
      resp_pending_d = 1'b1;
    end
    if (pop) begin
      rsp_valid_d     = 1'b1;
      rsp_read_data_d = load_data;
    end

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{fmt: req_format, off: off};
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus_address_q      <= '0;
      bus_read_enable_q  <= 1'b0;
      bus_write_enable_q <= 1'b0;
      bus_byte_enable_q  <= '0;
      bus_write_data_q   <= '0;
      rsp_valid_q        <= 1'b0;
      rsp_read_data_q    <= '0;
      rsp_error_q        <= 1'b0;
      resp_pending_q     <= 1'b0;
      fifo_q             <= '{default: '0};
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      cnt_q              <= '0;
    end else begin
      bus_address_q      <= bus_address_d;
      bus_read_enable_q  <= bus_read_enable_d;
      bus_write_enable_q <= bus_write_enable_d;
      bus_byte_enable_q  <= bus_byte_enable_d;
      bus_write_data_q   <= bus_write_data_d;
      rsp_valid_q        <= rsp_valid_d;
      rsp_read_data_q    <= rsp_read_data_d;
      rsp_error_q        <= rsp_error_d;
      resp_pending_q     <= resp_pending_d;
      fifo_q             <= fifo_d;
      wr_ptr_q           <= wr_ptr_d;
      rd_ptr_q           <= rd_ptr_d;
      cnt_q              <= cnt_d;
    end
  end

  assign bus_address      = bus_address_q;
  assign bus_read_enable  = bus_read_enable_q;
  assign bus_write_enable = bus_write_enable_q;
  assign bus_byte_enable  = bus_byte_enable_q;
  assign bus_write_data   = bus_write_data_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_read_data    = rsp_read_data_q;
  assign rsp_error        = rsp_error_q;

endmodule

// File: tb/tb_pipelined_memory_interface.sv
// Bench for pipelined_memory_interface: directed cycle table followed by
// random traffic against a queue-based reference model.
module tb_pipelined_memory_interface;

  localparam int unsigned AW   = 32;
  localparam int unsigned MAXO = 2;
  localparam int          NCYC = 3000;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [2:0]    req_format;
  logic [AW-1:0] req_address;
  logic [31:0]   req_write_data;
  logic          rsp_valid, rsp_error;
  logic [31:0]   rsp_read_data;
  logic [AW-1:0] bus_address;
  logic          bus_read_enable, bus_write_enable;
  logic [3:0]    bus_byte_enable;
  logic [31:0]   bus_write_data;
  logic          bus_wait_req, bus_valid;
  logic [31:0]   bus_read_data;

  pipelined_memory_interface #(
    .ADDR_WIDTH     (AW),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_format      (req_format),
    .req_address     (req_address),
    .req_write_data  (req_write_data),
    .rsp_valid       (rsp_valid),
    .rsp_read_data   (rsp_read_data),
    .rsp_error       (rsp_error),
    .bus_address     (bus_address),
    .bus_read_enable (bus_read_enable),
    .bus_write_enable(bus_write_enable),
    .bus_byte_enable (bus_byte_enable),
    .bus_write_data  (bus_write_data),
    .bus_wait_req    (bus_wait_req),
    .bus_valid       (bus_valid),
    .bus_read_data   (bus_read_data)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One row per clock: inputs driven on the falling edge, outputs checked just after.
  typedef struct {
    logic rst, v, w; logic [2:0] fmt; logic [31:0] addr, wd; logic wt, bv; logic [31:0] rd;
    logic rdy, re, we; logic [3:0] be; logic [31:0] ba, bwd; logic rv; logic [31:0] rdat;
    logic err;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input int rst, v, w, fmt, addr, wd, wt, bv, rd,
                     input int rdy, re, we, be, ba, bwd, rv, rdat, err);
    vec_t r;
    r.rst = rst[0]; r.v = v[0]; r.w = w[0]; r.fmt = fmt[2:0]; r.addr = addr; r.wd = wd;
    r.wt = wt[0]; r.bv = bv[0]; r.rd = rd; r.rdy = rdy[0]; r.re = re[0]; r.we = we[0];
    r.be = be[3:0]; r.ba = ba; r.bwd = bwd; r.rv = rv[0]; r.rdat = rdat; r.err = err[0];
    vecs.push_back(r);
  endtask

  task automatic idle(input int rdy);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, rdy, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reference model helpers, written from the lane/extension rules.
  function automatic int fmt_size(input logic [2:0] fmt);
    return (fmt[1:0] == 2'b00) ? 1 : (fmt[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] fmt, input logic [31:0] addr);
    return (int'(addr[1:0]) % fmt_size(fmt)) != 0;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] data, input logic [2:0] fmt,
                                         input logic [1:0] off);
    longint val, m;
    int sz;
    sz  = fmt_size(fmt);
    val = longint'(data) >> (8 * int'(off));
    if (sz == 4) return val[31:0];
    m   = longint'(1) << (8 * sz);
    val = val % m;
    if (!fmt[2] && val >= m / 2) val = val - m;
    return val[31:0];
  endfunction

  typedef struct { logic w; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; } cmd_t;
  typedef struct { logic [2:0] fmt; logic [1:0] off; } ld_t;
  cmd_t cmdq[$];
  ld_t  loadq[$];
  int   retq[$];

  logic [2:0] fmts [5];

  initial begin
    logic        exp_rv, exp_err, exp_pend, exp_rdy;
    logic [31:0] exp_rdat;
    logic        nrv, nerr, npend, mis;
    logic [31:0] nrdat;
    cmd_t        c;
    ld_t         l;
    int          sz, t;
    longint      shifted_wd;

    fmts = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    reset = 1'b1; req_valid = 0; req_write = 0; req_format = 0; req_address = 0;
    req_write_data = 0; bus_wait_req = 0; bus_valid = 0; bus_read_data = 0;
    repeat (2) @(negedge clock);

    // rst v w fmt addr wd wt bv rd | rdy re we be ba bwd rv rdat err
    idle(1);
    add(0, 1, 0, 2, 'h100, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'hf, 'h100, 0, 0, 0, 0);
    idle(1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 'hdeadbeef, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 'hdeadbeef, 0);
    add(0, 1, 0, 0, 'h103, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'h8, 'h100, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 'h80112233, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4, 'h103, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 'hffffff80, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 'h80112233, 1, 1, 0, 'h8, 'h100, 0, 0, 0, 0);
    add(0, 1, 0, 5, 'h102, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 'h80, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 'h80112233, 1, 1, 0, 'hc, 'h100, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 'h8011, 0);
    // SH with three wait cycles, store request kept on the request lines
    add(0, 1, 1, 1, 'h202, 'h1234, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) add(0, 0, 1, 1, 'h202, 'h1234, 1, 0, 0, 0, 0, 1, 'hc, 'h200, 'h12340000, 0, 0, 0);
    add(0, 0, 1, 1, 'h202, 'h1234, 0, 0, 0, 0, 0, 1, 'hc, 'h200, 'h12340000, 0, 0, 0);
    add(0, 0, 1, 1, 'h202, 'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);
    // misaligned LW
    add(0, 1, 0, 2, 'h101, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(1);
    // three back-to-back LW against two outstanding slots
    add(0, 1, 0, 2, 'h300, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 2, 'h304, 0, 0, 0, 0, 1, 1, 0, 'hf, 'h300, 0, 0, 0, 0);
    add(0, 1, 0, 2, 'h308, 0, 0, 0, 0, 0, 1, 0, 'hf, 'h304, 0, 0, 0, 0);
    add(0, 1, 0, 2, 'h308, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 2, 'h308, 0, 0, 1, 'h11111111, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 2, 'h308, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 'h11111111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 'h22222222, 0, 1, 0, 'hf, 'h308, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 'h33333333, 1, 0, 0, 0, 0, 0, 1, 'h22222222, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 'h33333333, 0);
    idle(1);
    // reset with two loads outstanding, then a stray bus_valid
    add(0, 1, 0, 2, 'h400, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 2, 'h404, 0, 0, 0, 0, 1, 1, 0, 'hf, 'h400, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'hf, 'h404, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 'h55555555, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      reset = vecs[i].rst; req_valid = vecs[i].v; req_write = vecs[i].w;
      req_format = vecs[i].fmt; req_address = vecs[i].addr; req_write_data = vecs[i].wd;
      bus_wait_req = vecs[i].wt; bus_valid = vecs[i].bv; bus_read_data = vecs[i].rd;
      #1;
      chk($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(vecs[i].rdy));
      chk($sformatf("row%0d bus_read_enable", i), 32'(bus_read_enable), 32'(vecs[i].re));
      chk($sformatf("row%0d bus_write_enable", i), 32'(bus_write_enable), 32'(vecs[i].we));
      chk($sformatf("row%0d bus_byte_enable", i), 32'(bus_byte_enable), 32'(vecs[i].be));
      chk($sformatf("row%0d bus_address", i), bus_address, vecs[i].ba);
      chk($sformatf("row%0d bus_write_data", i), bus_write_data, vecs[i].bwd);
      chk($sformatf("row%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].rv));
      chk($sformatf("row%0d rsp_read_data", i), rsp_read_data, vecs[i].rdat);
      chk($sformatf("row%0d rsp_error", i), 32'(rsp_error), 32'(vecs[i].err));
    end

    // Random traffic against the queue model.
    @(negedge clock);
    reset = 1'b1; req_valid = 0; bus_valid = 0; bus_wait_req = 0;
    exp_rv = 0; exp_err = 0; exp_pend = 0; exp_rdat = 0;
    for (int cyc = 0; cyc < NCYC + 60; cyc++) begin
      @(negedge clock);
      reset          = 1'b0;
      req_valid      = (cyc < NCYC) && ($urandom_range(0, 9) < 6);
      req_write      = ($urandom_range(0, 3) == 0);
      req_format     = fmts[int'($urandom_range(0, 4))];
      req_address    = $urandom & 32'h3ff;
      req_write_data = $urandom;
      if ($urandom_range(0, 9) < 7) begin
        if (fmt_size(req_format) == 2) req_address[0] = 1'b0;
        if (fmt_size(req_format) == 4) req_address[1:0] = 2'b00;
      end
      bus_wait_req  = ($urandom_range(0, 9) < 3);
      bus_read_data = $urandom;
      if (retq.size() > 0 && retq[0] <= cyc) begin
        bus_valid = 1'b1;
        void'(retq.pop_front());
      end else begin
        bus_valid = (loadq.size() == 0) && ($urandom_range(0, 7) == 0);
      end
      #1;

      mis     = is_misaligned(req_format, req_address);
      exp_rdy = (cmdq.size() == 0 || !bus_wait_req) && (loadq.size() < MAXO) &&
                ((!req_write && !mis) ||
                 (loadq.size() == 0 && cmdq.size() == 0 && !exp_pend));
      chk($sformatf("rand%0d req_ready", cyc), 32'(req_ready), 32'(exp_rdy));
      chk($sformatf("rand%0d rsp_valid", cyc), 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
        chk($sformatf("rand%0d rsp_read_data", cyc), rsp_read_data, exp_rdat);
        chk($sformatf("rand%0d rsp_error", cyc), 32'(rsp_error), 32'(exp_err));
      end
      chk($sformatf("rand%0d cmd_active", cyc), 32'(bus_read_enable || bus_write_enable),
          32'(cmdq.size() > 0));
      if (cmdq.size() > 0) begin
        chk($sformatf("rand%0d bus_write_enable", cyc), 32'(bus_write_enable),
            32'(cmdq[0].w));
        chk($sformatf("rand%0d bus_read_enable", cyc), 32'(bus_read_enable),
            32'(!cmdq[0].w));
        chk($sformatf("rand%0d bus_address", cyc), bus_address, cmdq[0].addr);
        chk($sformatf("rand%0d bus_byte_enable", cyc), 32'(bus_byte_enable),
            32'(cmdq[0].be));
        if (cmdq[0].w)
          chk($sformatf("rand%0d bus_write_data", cyc), bus_write_data, cmdq[0].wd);
      end

      nrv = 0; nerr = 0; npend = 0; nrdat = 0;
      if (cmdq.size() > 0 && !bus_wait_req) begin
        c = cmdq.pop_front();
        if (c.w) begin
          nrv = 1; npend = 1;
        end else begin
          t = cyc + 1 + int'($urandom_range(0, 3));
          if (retq.size() > 0 && t <= retq[$]) t = retq[$] + 1;
          retq.push_back(t);
        end
      end
      if (bus_valid && loadq.size() > 0) begin
        l = loadq.pop_front();
        chk($sformatf("rand%0d no response collision", cyc), 32'(nrv), 0);
        nrv = 1; nrdat = extend(bus_read_data, l.fmt, l.off);
      end
      if (req_valid && exp_rdy) begin
        if (mis) begin
          chk($sformatf("rand%0d no response collision", cyc), 32'(nrv), 0);
          nrv = 1; nerr = 1; npend = 1;
        end else begin
          sz         = fmt_size(req_format);
          c.w        = req_write;
          c.addr     = req_address & ~32'h3;
          c.be       = (sz == 4) ? 4'hf : 4'(((1 << sz) - 1) << int'(req_address[1:0]));
          shifted_wd = longint'(req_write_data) << (8 * int'(req_address[1:0]));
          c.wd       = shifted_wd[31:0];
          cmdq.push_back(c);
          if (!req_write) loadq.push_back('{fmt: req_format, off: req_address[1:0]});
        end
      end
      exp_rv = nrv; exp_err = nerr; exp_pend = npend; exp_rdat = nrdat;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pipelined_memory_interface.md
Name: pipelined_memory_interface

Overview:
- Parametrised successor to the single-access data memory interface used by the multicycle core.
- Accepts load/store requests from the core with a valid/ready handshake and drives the shared memory bus through a registered command stage.
- Keeps up to MAX_OUTSTANDING reads in flight and returns sign/zero-extended load results in order.
- Detects misaligned accesses without touching the bus.

Parameters:
- ADDR_WIDTH, 32, width of request and bus address.
- MAX_OUTSTANDING, 2, maximum reads issued but not yet returned; power of two, ≥1.

Ports:
- clock  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_format  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_address  in  ADDR_WIDTH  byte address.
- req_write_data  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_read_data  out  32  extended load data; 0 for stores and errors.
- rsp_error  out  1  qualifies rsp_valid; misaligned request.
- bus_address  out  ADDR_WIDTH  word-aligned address (low 2 bits 0).
- bus_read_enable  out  1  read command.
- bus_write_enable  out  1  write command.
- bus_byte_enable  out  4  lane enables.
- bus_write_data  out  32  lane-shifted store data.
- bus_wait_req  in  1  bus stalls the current command.
- bus_valid  in  1  read data returned this cycle.
- bus_read_data  in  32  raw word.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset state: all outputs 0 except req_ready = 1. Command register cleared. Tracking FIFO emptied. A reset mid-transaction drops all in-flight state; any bus_valid arriving afterwards is ignored.
- Command stage: an accepted, aligned request loads the bus_* registers on the next edge, so the command appears one cycle after acceptance.
  - The command is held stable while bus_wait_req = 1.
  - The command is consumed in a cycle where it is active and bus_wait_req = 0. Enables drop next cycle unless a new request is loaded in the same cycle (back-to-back allowed).
- Lane mapping uses off = addr[1:0].
  - B: be = 0001 << off.
  - H: be = 0011 << off.
  - W: be = 1111.
  - bus_write_data = req_write_data << (8*off).
- Misaligned requests: H with addr[0] = 1, or W with off ≠ 0.
  - No bus command is issued.
  - Response is rsp_valid = 1, rsp_error = 1 one cycle after acceptance.
  - Accepted only when the FIFO is empty and no command is active, which preserves response order.
- Tracking FIFO, depth MAX_OUTSTANDING:
  - Each accepted aligned load pushes {format, off}.
  - Each bus_valid pops the head. Data is shifted right by 8*off, then sign- or zero-extended per format, and registered.
  - rsp_valid is asserted the cycle after bus_valid.
  - A simultaneous push and pop in the same cycle leaves the count unchanged.
  - bus_valid with an empty FIFO is ignored.
- Stores:
  - Accepted only when the FIFO is empty and no command is active.
  - Response rsp_valid = 1, rsp_error = 0 in the cycle after the write command is consumed.
- req_ready = (!cmd_active || !bus_wait_req) && fifo_count < MAX_OUTSTANDING && (load-aligned || (fifo_count == 0 && !cmd_active && !resp_pending)).
  - req_ready is combinational from req_* and state; it never depends on bus_valid in the same cycle.
- At most one rsp_valid per cycle. An error or store response can never collide with a load response, because of the ordering rules above.

Test Plan:
- LW at 0x100, bus_wait_req = 0, bus returns 0xDEADBEEF two cycles after the command → bus_read_enable one cycle after accept with be = 1111; rsp_read_data = 0xDEADBEEF one cycle after bus_valid.
- LB at 0x103 returning 0x80112233 → be = 1000, rsp = 0xFFFFFF80. LBU same → 0x00000080. LHU at 0x102 → 0x00008011.
- SH 0x1234 at 0x202 with bus_wait_req high for 3 cycles → command stable for 4 cycles, be = 1100, bus_write_data = 0x12340000; rsp_valid the cycle after wait_req drops; req_ready low throughout.
- MAX_OUTSTANDING = 2: three back-to-back LW, bus_valid delayed → third held off (req_ready = 0) until first bus_valid; responses in issue order.
- LW at 0x101 → no bus enable asserted, rsp_error = 1 after one cycle; assert reset with two loads outstanding, then late bus_valid → no rsp_valid, req_ready = 1.
